// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider for MULT, MULTU, DIV, DIVU.
// One iteration per cycle; finish pulses for one cycle when HI/LO are updated.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   orig_a;
    logic [WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0] acc;

    logic               accept;
    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   part;
    logic               ge;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] acc_nxt;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   q_res;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign busy   = (state == CALC);
    assign finish = (state == DONE);
    assign accept = start && (state == IDLE || state == DONE);

    // Operand conditioning: magnitudes for signed ops, raw bits otherwise.
    always_comb begin
        sgn_a = ~op[0] & a[WIDTH-1];
        sgn_b = ~op[0] & b[WIDTH-1];
        mag_a = sgn_a ? (~a + 1'b1) : a;
        mag_b = sgn_b ? (~b + 1'b1) : b;
    end

    // Multiply step: add addend into upper half when LSB set, shift right.
    always_comb begin
        msum = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, addend} : '0);
        mul_nxt = {msum, acc[WIDTH-1:1]};
    end

    // Divide step: acc holds {remainder, dividend bits still to shift}.
    always_comb begin
        rem  = acc[2*WIDTH-1:WIDTH];
        quo  = acc[WIDTH-1:0];
        part = {rem[WIDTH-2:0], quo[WIDTH-1]};
        ge   = rem[WIDTH-1] | (part >= addend);
        if (ge) begin
            div_nxt = {part - addend, quo[WIDTH-2:0], 1'b1};
        end else begin
            div_nxt = {part, quo[WIDTH-2:0], 1'b0};
        end
    end

    assign acc_nxt = is_div ? div_nxt : mul_nxt;

    always_comb begin
        prod   = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
        q_res  = acc_nxt[WIDTH-1:0];
        r_res  = acc_nxt[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_lo = neg_q ? (~q_res + 1'b1) : q_res;
            res_hi = neg_r ? (~r_res + 1'b1) : r_res;
            if (div_zero) begin
                res_hi = orig_a;
                res_lo = '1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            orig_a   <= '0;
            addend   <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt      <= '0;
                is_div   <= op[1];
                neg_q    <= sgn_a ^ sgn_b;
                neg_r    <= sgn_a;
                div_zero <= (b == '0);
                orig_a   <= a;
                // Multiply adds |a| against |b| bits; divide subtracts |b|.
                addend   <= op[1] ? mag_b : mag_a;
                acc      <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
            end else if (state == CALC) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against an arithmetic model.
// Per-cycle compare of busy/finish/hi/lo plus literal result checks.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         finish;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int passed = 0;
    int total = 0;

    int           age = -1;
    bit           mvalid = 1'b0;
    logic [W-1:0] vis_hi = '0;
    logic [W-1:0] vis_lo = '0;
    logic [63:0]  pend = '0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .busy(busy),
        .finish(finish),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_op(input logic [1:0] fop,
                                           input logic [31:0] fa,
                                           input logic [31:0] fb);
        logic [63:0] r;
        longint sa;
        longint sb;
        longint q;
        longint m;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        r = '0;
        case (fop)
            2'b00: r = 64'(sa * sb);
            2'b01: r = {32'b0, fa} * {32'b0, fb};
            2'b10: begin
                if (fb == 0) begin
                    r = {fa, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (fb == 0) r = {fa, 32'hFFFFFFFF};
                else r = {fa % fb, fa / fb};
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Timeline model: age counts cycles since the accepted start edge.
    always @(posedge clk) begin
        if (reset) begin
            mvalid <= 1'b1;
            age    <= -1;
            vis_hi <= '0;
            vis_lo <= '0;
        end else if (age >= 1 && age <= W) begin
            age <= age + 1;
            if (age == W) begin
                vis_hi <= pend[63:32];
                vis_lo <= pend[31:0];
            end
        end else if (start) begin
            age  <= 1;
            pend <= ref_op(op, a, b);
        end else begin
            age <= -1;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("busy", 64'(busy), 64'(age >= 1 && age <= W));
            check("finish", 64'(finish), 64'(age == W + 1));
            check("hi", 64'(hi), 64'(vis_hi));
            check("lo", 64'(lo), 64'(vis_lo));
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(input int n0, input logic [31:0] eh,
                               input logic [31:0] el, input string tag);
        int n;
        n = n0;
        while (finish !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(W + 1));
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        logic [63:0] e;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen;

        check("pin_mult", ref_op(2'b00, 32'hFFFFFFFD, 32'd5),
              64'hFFFFFFFF_FFFFFFF1);
        check("pin_multu", ref_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF),
              64'hFFFFFFFE_00000001);
        check("pin_divu", ref_op(2'b11, 32'd100, 32'd7),
              64'h00000002_0000000E);
        check("pin_div", ref_op(2'b10, 32'hFFFFFFF9, 32'd2),
              64'hFFFFFFFF_FFFFFFFD);
        check("pin_ovf", ref_op(2'b10, 32'h80000000, 32'hFFFFFFFF),
              64'h00000000_80000000);
        check("pin_dz", ref_op(2'b10, 32'h12345678, 32'd0),
              64'h12345678_FFFFFFFF);

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(2'b00, 32'hFFFFFFFD, 32'd5);
        wait_finish(1, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult");
        @(negedge clk);

        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_finish(1, 32'hFFFFFFFE, 32'h00000001, "multu");
        do_op(2'b11, 32'd100, 32'd7);
        wait_finish(1, 32'd2, 32'd14, "divu_b2b");
        @(negedge clk);

        do_op(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_finish(1, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        @(negedge clk);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_finish(1, 32'h00000000, 32'h80000000, "div_ovf");
        @(negedge clk);

        do_op(2'b11, 32'h12345678, 32'd0);
        wait_finish(1, 32'h12345678, 32'hFFFFFFFF, "divu_z");
        @(negedge clk);
        do_op(2'b10, 32'h12345678, 32'd0);
        wait_finish(1, 32'h12345678, 32'hFFFFFFFF, "div_z");
        @(negedge clk);

        do_op(2'b00, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        start = 1'b1;
        a = 32'd1000;
        b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_finish(11, 32'd0, 32'd42, "ign_start");
        @(negedge clk);

        do_op(2'b00, 32'd6, 32'd7);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (finish === 1'b1) seen++;
        end
        check("mid_rst_nofin", 64'(seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = '1;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            e = ref_op(ro, ra, rb);
            do_op(ro, ra, rb);
            wait_finish(1, e[63:32], e[31:0], "rand");
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
